// File: rtl/traffic_pkg.sv
// Shared state encoding, phase width and default phase durations (in ticks)
// for the two-way traffic-light controller.
package traffic_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_EW_G = 3'd2,
    S_EW_Y = 3'd3,
    S_WALK = 3'd4
  } state_e;

  localparam int DEF_NS_GREEN_TICKS  = 5;
  localparam int DEF_NS_YELLOW_TICKS = 2;
  localparam int DEF_EW_GREEN_TICKS  = 5;
  localparam int DEF_EW_YELLOW_TICKS = 2;
  localparam int DEF_WALK_TICKS      = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter only has to reach max_dur-1; never narrower than one bit.
  function automatic int cnt_width(input int max_dur);
    return (max_dur <= 2) ? 1 : $clog2(max_dur);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: counts tick pulses and raises done on the tick
// that completes the current phase duration, then restarts from zero.
module phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           load,
  input  logic [CNT_W:0] dur,
  output logic           done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = tick && ({1'b0, cnt_q} == (dur - (CNT_W + 1)'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (load || done) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way Moore traffic-light FSM advancing on tick pulses, with sticky
// tick-width error flag. Define PED_WALK_EN to add the pedestrian all-red phase.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int NS_GREEN_TICKS  = DEF_NS_GREEN_TICKS,
  parameter int NS_YELLOW_TICKS = DEF_NS_YELLOW_TICKS,
  parameter int EW_GREEN_TICKS  = DEF_EW_GREEN_TICKS,
  parameter int EW_YELLOW_TICKS = DEF_EW_YELLOW_TICKS,
  parameter int WALK_TICKS      = DEF_WALK_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
`ifdef PED_WALK_EN
  input  logic               ped_req,
  output logic               walk,
`endif
  output logic               ns_g,
  output logic               ns_y,
  output logic               ns_r,
  output logic               ew_g,
  output logic               ew_y,
  output logic               ew_r,
  output logic [PHASE_W-1:0] phase,
  output logic               tick_err
);

  localparam int MAX_DUR = max_int(max_int(max_int(NS_GREEN_TICKS, NS_YELLOW_TICKS),
                                           max_int(EW_GREEN_TICKS, EW_YELLOW_TICKS)),
                                   WALK_TICKS);
  localparam int CNT_W = cnt_width(MAX_DUR);
  localparam int DUR_W = CNT_W + 1;

  state_e           state_q, state_d;
  logic [DUR_W-1:0] dur;
  logic             load, done;
  logic             tick_q, tick_err_q;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .load (load),
    .dur  (dur),
    .done (done)
  );

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    dur = DUR_W'(1);
    case (state_q)
      S_NS_G:  dur = DUR_W'(NS_GREEN_TICKS);
      S_NS_Y:  dur = DUR_W'(NS_YELLOW_TICKS);
      S_EW_G:  dur = DUR_W'(EW_GREEN_TICKS);
      S_EW_Y:  dur = DUR_W'(EW_YELLOW_TICKS);
`ifdef PED_WALK_EN
      S_WALK:  dur = DUR_W'(WALK_TICKS);
`endif
      default: dur = DUR_W'(1);
    endcase
  end

`ifdef PED_WALK_EN
  logic pend_q, pend_d;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_NS_G: if (done) state_d = S_NS_Y;
      S_NS_Y: if (done) state_d = S_EW_G;
      S_EW_G: if (done) state_d = S_EW_Y;
      S_EW_Y: begin
        if (done) begin
`ifdef PED_WALK_EN
          // A request landing on the terminal edge itself still wins the walk.
          state_d = (pend_q || ped_req) ? S_WALK : S_NS_G;
`else
          state_d = S_NS_G;
`endif
        end
      end
`ifdef PED_WALK_EN
      S_WALK: if (done) state_d = S_NS_G;
`endif
      default: begin
        state_d = S_NS_G;
        load    = 1'b1;
      end
    endcase
  end

`ifdef PED_WALK_EN
  always_comb begin
    pend_d = pend_q;
    if (state_d == S_WALK && state_q != S_WALK) begin
      pend_d = 1'b0;
    end else if (ped_req && state_q != S_WALK) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_NS_G;
      tick_q     <= 1'b0;
      tick_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick;
      tick_err_q <= tick_err_q | (tick & tick_q);
    end
  end

  always_comb begin
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = 6'b000000;
`ifdef PED_WALK_EN
    walk = 1'b0;
`endif
    case (state_q)
      S_NS_G: begin ns_g = 1'b1; ew_r = 1'b1; end
      S_NS_Y: begin ns_y = 1'b1; ew_r = 1'b1; end
      S_EW_G: begin ew_g = 1'b1; ns_r = 1'b1; end
      S_EW_Y: begin ew_y = 1'b1; ns_r = 1'b1; end
`ifdef PED_WALK_EN
      S_WALK: begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
`endif
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

  assign phase    = state_q;
  assign tick_err = tick_err_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: stimulus queues expected phase and
// error state; a negedge monitor pops and compares, plus per-cycle lamp checks.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic [2:0] phase;
  logic       tick_err;
`ifdef PED_WALK_EN
  logic       ped_req;
  logic       walk;
`endif

  traffic_light_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
`ifdef PED_WALK_EN
    .ped_req  (ped_req),
    .walk     (walk),
`endif
    .ns_g     (ns_g),
    .ns_y     (ns_y),
    .ns_r     (ns_r),
    .ew_g     (ew_g),
    .ew_y     (ew_y),
    .ew_r     (ew_r),
    .phase    (phase),
    .tick_err (tick_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] phase;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} for each phase code
  function automatic logic [5:0] lamps_for(input logic [2:0] p);
    case (p)
      3'd0:    return 6'b100_001;
      3'd1:    return 6'b010_001;
      3'd2:    return 6'b001_100;
      3'd3:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t       e;
    logic       walk_bit;
    logic [10:0] got, want;
`ifdef PED_WALK_EN
    walk_bit = walk;
`else
    walk_bit = 1'b0;
`endif
    n_vec++;
    if (!$onehot({ns_g, ns_y, ns_r}) || !$onehot({ew_g, ew_y, ew_r}) || (ns_g && ew_g)) begin
      n_bad++;
      $display("FAIL lamp_invariant t=%0t got ns=%b ew=%b required one-hot each and no dual green",
               $time, {ns_g, ns_y, ns_r}, {ew_g, ew_y, ew_r});
    end
    while (exp_q.size() != 0) begin
      e    = exp_q.pop_front();
      got  = {phase, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, tick_err, walk_bit};
      want = {e.phase, lamps_for(e.phase), e.err, (e.phase == 3'd4)};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s t=%0t got {phase,lamps,err,walk}=%b required %b",
                 e.name, $time, got, want);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic expect_now(input string nm, input logic [2:0] p, input logic err);
    exp_t e;
    e.name  = nm;
    e.phase = p;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  logic [2:0] cycle_tbl [14] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                                 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
`ifdef PED_WALK_EN
    ped_req = 1'b0;
`endif
    // Reset held 3 cycles with a tick inside it that must be ignored.
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    rst = 1'b0;
    expect_now("reset_release", 3'd0, 1'b0);

    // Full cycle: 5 NS_G, 2 NS_Y, 5 EW_G, 2 EW_Y, back to NS_G.
    for (int k = 0; k < 14; k++) begin
      tick_once();
      expect_now($sformatf("cycle_tick%0d", k + 1), cycle_tbl[k], 1'b0);
    end

    // Tick hold in EW_G with cnt=2.
    repeat (9) tick_once();
    expect_now("hold_entry", 3'd2, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (i % 25 == 24) expect_now($sformatf("hold_clk%0d", i + 1), 3'd2, 1'b0);
    end
    tick_once();
    expect_now("hold_resume1", 3'd2, 1'b0);
    tick_once();
    expect_now("hold_resume2", 3'd2, 1'b0);
    tick_once();
    expect_now("hold_resume_done", 3'd3, 1'b0);

    // Asynchronous reset mid EW_Y, raised between clock edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    expect_now("async_reset", 3'd0, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    repeat (4) tick_once();
    expect_now("post_reset_4ticks", 3'd0, 1'b0);
    tick_once();
    expect_now("post_reset_5ticks", 3'd1, 1'b0);

    // Two-cycle tick pulse in NS_Y (cnt=0): counts twice and sets tick_err.
    tick = 1'b1;
    cyc();
    expect_now("err_first_cycle", 3'd1, 1'b0);
    cyc();
    tick = 1'b0;
    expect_now("err_set", 3'd2, 1'b1);
    repeat (5) tick_once();
    expect_now("err_sticky", 3'd3, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_now("err_cleared", 3'd0, 1'b0);

`ifdef PED_WALK_EN
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    repeat (13) tick_once();
    expect_now("ped_ew_y", 3'd3, 1'b0);
    tick_once();
    expect_now("walk_enter", 3'd4, 1'b0);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    repeat (2) tick_once();
    expect_now("walk_hold", 3'd4, 1'b0);
    tick_once();
    expect_now("walk_exit", 3'd0, 1'b0);
    repeat (13) tick_once();
    expect_now("noped_ew_y", 3'd3, 1'b0);
    tick_once();
    expect_now("noped_skip_walk", 3'd0, 1'b0);
    repeat (13) tick_once();
    tick    = 1'b1;
    ped_req = 1'b1;
    cyc();
    tick    = 1'b0;
    ped_req = 1'b0;
    expect_now("ped_same_edge", 3'd4, 1'b0);
    repeat (3) cyc();
    repeat (3) tick_once();
    expect_now("ped_same_edge_exit", 3'd0, 1'b0);
`endif

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
